// File: rtl/pipe_stage_buffer.sv
// Generic inter-stage pipeline register with a 2-entry skid (main + skid) and flush-to-bubble.
// Latency: 1 cycle from accept to o_valid when empty; 1 word/cycle throughput with i_ready high.
// Backpressure: o_ready = !skid_v straight from a flop; no combinational path from i_ready.
// Optional statistics counters are enabled with `define PIPE_STAGE_BUFFER_STATS_EN.
module pipe_stage_buffer #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = {WIDTH{1'b0}},
    parameter int               CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_occupancy
`ifdef PIPE_STAGE_BUFFER_STATS_EN
    ,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             main_v, skid_v;
    logic             accept, emit;

    assign main_v      = (state_q != ST_EMPTY);
    assign skid_v      = (state_q == ST_FULL);
    assign o_valid     = main_v;
    assign o_ready     = !skid_v;
    // main_q is kept at BUBBLE_VALUE whenever it holds nothing, so it can drive o_data directly.
    assign o_data      = main_q;
    assign o_occupancy = {1'b0, main_v} + {1'b0, skid_v};
    assign accept      = i_valid & o_ready;
    assign emit        = o_valid & i_ready;

    // State and data registers; reset forces both slots to the bubble.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE_VALUE;
            skid_q  <= BUBBLE_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state and data steering; flush overrides every transition and drops the input.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VALUE;
            skid_d  = BUBBLE_VALUE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    main_d = BUBBLE_VALUE;
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = i_data;
                    end
                end
                ST_ONE: begin
                    case ({accept, emit})
                        2'b11: main_d = i_data;
                        2'b10: begin
                            state_d = ST_FULL;
                            skid_d  = i_data;
                        end
                        2'b01: begin
                            state_d = ST_EMPTY;
                            main_d  = BUBBLE_VALUE;
                        end
                        default: ;
                    endcase
                end
                ST_FULL: begin
                    // o_ready is low here, so only the drain of main is possible.
                    if (emit) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VALUE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VALUE;
                    skid_d  = BUBBLE_VALUE;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_BUFFER_STATS_EN
    logic stall_inc, bubble_inc;
    assign stall_inc  = i_valid & !o_ready;
    assign bubble_inc = !o_valid & i_ready;

    // Saturating stall/bubble counters; cleared by reset only, flush leaves them alone.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_stall_cnt  <= '0;
            o_bubble_cnt <= '0;
        end else begin
            if (stall_inc && (o_stall_cnt != {CNT_W{1'b1}}))
                o_stall_cnt <= o_stall_cnt + CNT_W'(1);
            if (bubble_inc && (o_bubble_cnt != {CNT_W{1'b1}}))
                o_bubble_cnt <= o_bubble_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
Parametrised inter-stage pipeline register for the pipelined RISC core. It replaces the fixed fetch/decode, decode/EXM and EXM/write-back buffers with one generic block.
- Carries a packed stage payload of WIDTH bits.
- Uses a valid/ready handshake with a 2-entry skid, so back-pressure does not create a combinational ready path across stages.
- Synchronous flush inserts a NOP bubble, used for LDM immediate slots, branches and interrupts.

Parameters:
WIDTH, 16, payload width in bits (instruction word or packed control+data bundle)
BUBBLE_VALUE, {WIDTH{1'b0}}, payload driven when no valid entry is held (decodes as NOP downstream)
CNT_W, 16, width of the statistics counters (used only with the optional feature)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_flush  in  1  synchronous flush; discards all held entries and any same-cycle input
i_valid  in  1  upstream has payload this cycle
o_ready  out  1  buffer can accept payload this cycle
i_data  in  WIDTH  upstream payload
o_valid  out  1  output payload is valid
i_ready  in  1  downstream accepts the output this cycle
o_data  out  WIDTH  output payload
o_occupancy  out  2  held entries, 0..2

Behaviour:
- Storage: main register (drives o_data) and skid register, each with its own valid bit. occupancy = main_v + skid_v.
- Transfers:
  - Accept = i_valid & o_ready.
  - Emit = o_valid & i_ready.
  - o_valid = main_v.
  - o_ready = !skid_v. It comes straight from a flop, with no combinational path from i_ready.
- States:
  - EMPTY (occupancy 0)
  - ONE (occupancy 1, main only)
  - FULL (occupancy 2)
- Transitions (no flush):
  - EMPTY: accept -> ONE, main<=i_data. Otherwise stay; main holds BUBBLE_VALUE.
  - ONE:
    - accept & emit -> ONE, main<=i_data.
    - accept only -> FULL, skid<=i_data.
    - emit only -> EMPTY, main<=BUBBLE_VALUE.
    - neither -> hold.
  - FULL: o_ready=0, so no accept. Emit -> ONE, main<=skid, skid<=BUBBLE_VALUE. Otherwise hold.
- Latency: 1 cycle from accept to o_valid when EMPTY. Throughput is 1 word/cycle when i_ready is held high.
- Ordering: strict FIFO. Skid contents always leave after main contents. No word is ever duplicated or dropped unless flushed.
- o_data equals BUBBLE_VALUE whenever o_valid=0.
- Flush: on a clock edge with i_flush=1, regardless of state or other inputs:
  - main_v<=0, skid_v<=0, both data registers<=BUBBLE_VALUE.
  - The same-cycle accept is discarded.
  - The same-cycle emit still counts downstream, because downstream sampled it before the edge.
  - The next cycle shows o_ready=1 and o_valid=0.
- Reset (asynchronous, any time, including mid-transfer):
  - o_valid=0, o_ready=1, o_data=BUBBLE_VALUE, o_occupancy=0, skid=BUBBLE_VALUE.
  - Reset dominates flush.
- Boundaries:
  - i_valid while FULL is ignored; the upstream must hold its data.
  - i_ready while EMPTY has no effect.
  - i_data is not sampled unless an accept occurs.
  - X on i_data while i_valid=0 must not propagate to o_data.

Optional Feature:
Macro PIPE_STAGE_BUFFER_STATS_EN.
- Defined: adds ports o_stall_cnt out CNT_W and o_bubble_cnt out CNT_W.
  - o_stall_cnt increments on cycles with i_valid & !o_ready.
  - o_bubble_cnt increments on cycles with !o_valid & i_ready.
  - Both saturate at all-ones, reset to 0 on i_reset only (not on i_flush), and are registered (value reflects cycles up to the previous edge).
- Not defined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset then i_valid=1, i_ready=1, data 0x1001,0x1002,0x1003 on consecutive cycles -> o_data 0x1001,0x1002,0x1003 one cycle later, o_valid continuous, o_occupancy=1.
- Load 0xA0A0 and 0xB0B0 with i_ready=0 -> o_occupancy=2, o_ready=0, o_data=0xA0A0. Present 0xC0C0 while FULL -> ignored. Raise i_ready -> 0xA0A0 then 0xB0B0 emitted, o_ready=1 after the first emit.
- FULL (0x1111, 0x2222) plus i_flush=1 with i_valid=1, data 0x3333 -> next cycle o_valid=0, o_occupancy=0, o_data=BUBBLE_VALUE, and 0x3333 never appears.
- Assert i_reset asynchronously mid-cycle while FULL -> outputs go to reset values before the next clock edge. After release, 0x4444 passes with 1-cycle latency.
- Random i_valid/i_ready (≥10k cycles, WIDTH=37) against a scoreboard -> output sequence equals accepted input sequence, no loss or duplication, o_ready never depends combinationally on i_ready.
- With STATS_EN: hold i_valid=1, i_ready=0 for 5 cycles from EMPTY -> o_stall_cnt=3. Then after reset hold i_valid=0, i_ready=1 for 4 cycles -> o_bubble_cnt=4. Force CNT_W=2 -> counters stick at 3.
